// File: rtl/spi_slave_pkg.sv
// Shared types and helpers for the SPI slave register file: FSM states,
// address-width and command-bit helpers.
package spi_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_WR   = 2'd2,
    ST_RD   = 2'd3
  } state_t;

  localparam int MIN_SYNC_STAGES = 2;

  // Minimum of one address bit so a 2-entry file still has a usable index.
  function automatic int addr_width(input int num_regs);
    return (num_regs <= 2) ? 1 : $clog2(num_regs);
  endfunction

  // The read/write flag sits in the MSB of the command frame.
  function automatic int cmd_rw_bit(input int data_w);
    return data_w - 1;
  endfunction

endpackage

// File: rtl/spi_slave_shifter.sv
// SPI pin front end: synchronisers, SCLK/SS edge detection, bit counter and
// the rx/tx shift registers. Reports completed words and partial-frame errors.
module spi_slave_shifter
  import spi_slave_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              ss_n,
  input  logic              tx_load,
  input  logic [DATA_W-1:0] tx_word,
  output logic              ss_active,
  output logic              rx_done,
  output logic [DATA_W-1:0] rx_word,
  output logic              miso_bit,
  output logic              frame_err
);

  localparam int   CNT_W         = $clog2(DATA_W);
  localparam logic SCLK_IDLE     = 1'(CPOL);
  localparam bit   SAMPLE_RISING = ((CPOL ^ CPHA) == 0);

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic [DATA_W-1:0]      r_rx_sr;
  logic [DATA_W-1:0]      r_rx_word;
  logic                   r_rx_done;
  logic                   r_frame_err;
  logic [DATA_W-1:0]      r_tx_sr;
  logic                   r_miso_bit;

  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_ss_fall;
  logic w_ss_rise;
  logic w_sample;
  logic w_shift;
  logic w_mosi;

  // sclk synchroniser idles at CPOL so reset release never looks like an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sclk_sync <= {SYNC_STAGES{SCLK_IDLE}};
      r_mosi_sync <= '0;
      r_ss_sync   <= '1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss_n};
    end
  end

  assign w_sclk_rise = r_sclk_sync[SYNC_STAGES-2] & ~r_sclk_sync[SYNC_STAGES-1];
  assign w_sclk_fall = ~r_sclk_sync[SYNC_STAGES-2] & r_sclk_sync[SYNC_STAGES-1];
  assign w_ss_fall   = ~r_ss_sync[SYNC_STAGES-2] & r_ss_sync[SYNC_STAGES-1];
  assign w_ss_rise   = r_ss_sync[SYNC_STAGES-2] & ~r_ss_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-2];
  assign ss_active   = ~r_ss_sync[SYNC_STAGES-2];

  assign w_sample = ss_active & (SAMPLE_RISING ? w_sclk_rise : w_sclk_fall);
  assign w_shift  = ss_active & (SAMPLE_RISING ? w_sclk_fall : w_sclk_rise);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_cnt   <= '0;
      r_rx_sr     <= '0;
      r_rx_word   <= '0;
      r_rx_done   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_done   <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_ss_fall) begin
        r_bit_cnt <= '0;
      end else if (w_ss_rise) begin
        r_frame_err <= (r_bit_cnt != '0);
        r_bit_cnt   <= '0;
      end else if (w_sample) begin
        r_rx_sr <= {r_rx_sr[DATA_W-2:0], w_mosi};
        if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
          r_bit_cnt <= '0;
          r_rx_done <= 1'b1;
          r_rx_word <= {r_rx_sr[DATA_W-2:0], w_mosi};
        end else begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end
    end
  end

  // CPHA=0: the trailing edge that closes a frame must not shift, so the freshly
  // loaded word's MSB stays on the line for the next frame's first sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_sr    <= '0;
      r_miso_bit <= 1'b0;
    end else begin
      if (tx_load) begin
        r_tx_sr <= tx_word;
      end else if (w_shift && (CPHA != 0 || r_bit_cnt != '0)) begin
        r_tx_sr    <= r_tx_sr << 1;
        r_miso_bit <= r_tx_sr[DATA_W-1];
      end
      if (w_ss_fall) begin
        r_miso_bit <= 1'b0;
      end
    end
  end

  assign miso_bit  = (CPHA == 0) ? r_tx_sr[DATA_W-1] : r_miso_bit;
  assign rx_done   = r_rx_done;
  assign rx_word   = r_rx_word;
  assign frame_err = r_frame_err;

endmodule

// File: rtl/spi_slave_regfile_p.sv
// SPI slave with an internal register file: command frame selects read/write
// and start address, followed by an auto-incrementing, wrapping burst.
module spi_slave_regfile_p
  import spi_slave_pkg::*;
#(
  parameter  int DATA_W      = 8,
  parameter  int NUM_REGS    = 4,
  parameter  int CPOL        = 0,
  parameter  int CPHA        = 0,
  parameter  int SYNC_STAGES = 2,
  localparam int ADDR_W      = addr_width(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              ss_n,
  output logic              miso,
  output logic              miso_oe,
  input  logic [ADDR_W-1:0] sys_rd_addr,
  output logic [DATA_W-1:0] sys_rd_data,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_err,
  output state_t            o_dbg_state
);

  localparam int RW_BIT = cmd_rw_bit(DATA_W);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [ADDR_W-1:0] w_addr_inc;
  logic [ADDR_W-1:0] w_cmd_addr;
  logic [DATA_W-1:0] r_regs [NUM_REGS];

  logic              w_ss_active;
  logic              w_rx_done;
  logic [DATA_W-1:0] w_rx_word;
  logic              w_miso_bit;
  logic              w_tx_load;
  logic [DATA_W-1:0] w_tx_word;
  logic              w_wr_en;

  spi_slave_shifter #(
    .DATA_W      (DATA_W),
    .CPOL        (CPOL),
    .CPHA        (CPHA),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_shifter (
    .clk       (clk),
    .reset     (reset),
    .sclk      (sclk),
    .mosi      (mosi),
    .ss_n      (ss_n),
    .tx_load   (w_tx_load),
    .tx_word   (w_tx_word),
    .ss_active (w_ss_active),
    .rx_done   (w_rx_done),
    .rx_word   (w_rx_word),
    .miso_bit  (w_miso_bit),
    .frame_err (frame_err)
  );

  // NUM_REGS is a power of two, so natural overflow gives the wrap to 0.
  assign w_addr_inc = r_addr + 1'b1;
  assign w_cmd_addr = w_rx_word[ADDR_W-1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_tx_load   = 1'b0;
    w_tx_word   = '0;
    w_wr_en     = 1'b0;
    if (!w_ss_active) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_CMD;
          w_tx_load   = 1'b1;
        end
        ST_CMD: begin
          if (w_rx_done) begin
            w_addr_nxt = w_cmd_addr;
            w_tx_load  = 1'b1;
            if (w_rx_word[RW_BIT]) begin
              w_state_nxt = ST_WR;
              w_tx_word   = w_rx_word;
            end else begin
              w_state_nxt = ST_RD;
              w_tx_word   = r_regs[w_cmd_addr];
            end
          end
        end
        ST_WR: begin
          if (w_rx_done) begin
            w_wr_en    = 1'b1;
            w_addr_nxt = w_addr_inc;
            w_tx_load  = 1'b1;
            w_tx_word  = w_rx_word;
          end
        end
        ST_RD: begin
          // Preload the next register now so a continuous burst has no gap frame.
          if (w_rx_done) begin
            w_addr_nxt = w_addr_inc;
            w_tx_load  = 1'b1;
            w_tx_word  = r_regs[w_addr_inc];
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[r_addr] <= w_rx_word;
    end
  end

  assign sys_rd_data = r_regs[sys_rd_addr];
  assign wr_valid    = w_wr_en;
  assign wr_addr     = w_wr_en ? r_addr : '0;
  assign wr_data     = w_wr_en ? w_rx_word : '0;
  assign miso_oe     = (r_state != ST_IDLE);
  assign miso        = miso_oe & w_miso_bit;
  assign o_dbg_state = r_state;

endmodule

// File: doc/spi_slave_regfile_p.md
Name: spi_slave_regfile_p

Overview:
Parametrised SPI slave with an internal register file, oversampled on the system clock clk.
- Supports all four SPI modes, configurable word width and register depth.
- Burst read/write with address auto-increment and wrap.
- Provides a system-side read port and a write-notify strobe.
- Sits between the external SPI pins (tristate is done at chip top) and on-chip logic that consumes configuration registers.

Parameters:
DATA_W, 8, word width of every SPI frame and register; legal range 8..32.
NUM_REGS, 4, register count; power of two, 2..256; ADDR_W = clog2(NUM_REGS).
CPOL, 0, SCLK idle level.
CPHA, 0, 0 = sample on leading edge / shift on trailing edge; 1 = shift on leading / sample on trailing.
SYNC_STAGES, 2, synchroniser depth for sclk, mosi and ss_n; minimum 2.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
sclk  in  1  SPI clock (async to clk)
mosi  in  1  SPI data in, MSB first
ss_n  in  1  slave select, active low
miso  out  1  SPI data out, MSB first; 0 when miso_oe=0
miso_oe  out  1  tristate enable for top-level pad; equals ~ss_n (synchronised)
sys_rd_addr  in  ADDR_W  system-side register read address
sys_rd_data  out  DATA_W  combinational read of regs[sys_rd_addr]
wr_valid  out  1  one-clk pulse when an SPI write commits
wr_addr  out  ADDR_W  address of committed write; valid with wr_valid
wr_data  out  DATA_W  data of committed write; valid with wr_valid
frame_err  out  1  one-clk pulse when ss_n rises with a partial frame

Behaviour:
- Reset values: all outputs 0; all registers 0; FSM IDLE. Synchroniser flops for sclk reset to CPOL, so there is no false edge after reset.
- Edge detection:
  - sample_edge = rising if CPOL^CPHA = 0, else falling.
  - shift_edge is the opposite edge.
  - Both are detected from the last two synchroniser stages.
  - Legal operation requires each SCLK half-period >= SYNC_STAGES+3 clk cycles.
- Frame handling:
  - A frame is DATA_W sample_edges.
  - The bit counter resets on every ss_n falling edge.
  - On the DATA_W-th sample the received word is complete (rx_done, internal, 1 clk).
- FSM IDLE:
  - miso_oe=0.
  - ss_n low -> CMD.
  - CPHA=0: on entry, load tx shift register with 0 so the first bit is valid before the first sample edge.
- FSM CMD:
  - The first frame is the command: bit DATA_W-1 = 1 write / 0 read; bits ADDR_W-1:0 = start address; other bits ignored.
  - MISO shifts out 0 during CMD.
  - On rx_done: addr <= cmd address.
    - Write -> WR, tx <= command word (echo).
    - Read -> RD, tx <= regs[cmd address].
  - The tx load must complete before the next shift_edge (guaranteed by the half-period rule).
- FSM WR:
  - Each rx_done writes regs[addr] <= rx word, pulses wr_valid/wr_addr/wr_data in the same clk, then advances addr.
  - tx <= the just-received word, so MISO echoes the previous frame.
- FSM RD:
  - Each completed frame advances addr and loads tx <= regs[addr+1], so a back-to-back burst has no dead frame.
  - MOSI content is ignored.
- Address wrap: addr increments modulo NUM_REGS (NUM_REGS-1 -> 0) in both WR and RD.
- ss_n rising in any state:
  - FSM -> IDLE in the next clk.
  - Partial frame discarded, no register write.
  - frame_err pulses iff bit counter != 0.
- A write and a system read of the same address in the same clk: sys_rd_data shows the old value that cycle and the new value the next cycle.
- ss_n falling during reset is ignored. Reset mid-transfer returns the block to the reset state immediately.
- Register contents survive ss_n toggling; only reset clears them.

Decomposition:
- Package spi_slave_pkg:
  - FSM state enum (IDLE, CMD, WR, RD)
  - CMD_RW_BIT = DATA_W-1
  - address-width helper function
- Sub-module spi_slave_shifter:
  - synchronisers, edge detection, bit counter
  - rx/tx shift registers
  - outputs: rx_done and rx_word; input: tx_load with tx_word
- The top level holds the FSM, register file and system ports.

Test Plan:
- Mode 0, DATA_W=8, NUM_REGS=4: write burst cmd 0x81, data 0x11, 0x22, 0x33 -> regs[1..3] = 11, 22, 33; three wr_valid pulses with addr 1, 2, 3; MISO frames read 00, 81, 11, 22.
- Same configuration, read burst cmd 0x02 then 4 dummy frames -> MISO returns 22, 33, 00(reg0 reset value), 11 (wrap 3 -> 0 -> 1).
- Run the write and read scenarios in modes 1, 2 and 3, and with DATA_W=16, NUM_REGS=8 (cmd 0x8007, data 0xBEEF, 0x1234) -> regs[7] = BEEF, regs[0] = 1234 (wrap); read back matches.
- ss_n raised after 5 bits of a write data frame -> no write, frame_err = 1 for one clk, next transaction starts cleanly with CMD.
- Reset asserted mid-burst -> all regs 0, miso_oe = 0, no wr_valid.
- System port: after the write scenario, sys_rd_addr = 2 -> sys_rd_data = 0x22; sys_rd_addr held on 1 during an SPI write of 0x5A -> old value shown in the commit cycle, 0x5A the next cycle.
